// File: rtl/disp_pkg.sv
// Shared types and default glyphs for the scrolling text buffer.
// Command codes, FSM states and the blank/caret character defaults.
package disp_pkg;

    typedef enum logic [1:0] {
        CMD_CHAR  = 2'd0,
        CMD_BKSP  = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_HOME  = 2'd3
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [7:0] DEF_BLANK_CHR = 8'h20;
    localparam logic [7:0] DEF_CARET_CHR = 8'h5F;

endpackage

// File: rtl/disp_caret_blink.sv
// Free-running caret blink divider: phase flips every BLINK_DIV cycles.
// Only instantiated when DISP_CARET_EN is defined.
module disp_caret_blink #(
    parameter int unsigned BLINK_DIV = 6000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_caret_phase
);

    localparam int unsigned CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;

    // count 0..BLINK_DIV-1, toggle the phase on each wrap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt           <= '0;
            o_caret_phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt           <= '0;
            o_caret_phase <= ~o_caret_phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scroll_buffer.sv
// Character line buffer with cursor, scroll-on-full and blinking caret.
// Define DISP_CARET_EN to build the blink counter and caret substitution.
module disp_scroll_buffer
    import disp_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = 8,
    parameter logic [DATA_W-1:0] CARET_CHR = DATA_W'(DEF_CARET_CHR),
    parameter logic [DATA_W-1:0] BLANK_CHR = DATA_W'(DEF_BLANK_CHR),
    parameter int unsigned BLINK_DIV = 6000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [1:0]               i_cmd,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [$clog2(DEPTH)-1:0] o_cursor,
    output logic                     o_full,
    output logic                     o_caret_phase
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state;
    logic [AW-1:0]     clr_idx;
    cmd_e              cmd;
    logic              caret_phase;
    logic              caret_hit;

    assign cmd = cmd_e'(i_cmd);

`ifdef DISP_CARET_EN
    disp_caret_blink #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_caret_phase(caret_phase)
    );
`else
    // no blink source; phase held low
    assign caret_phase = 1'b0 & (BLINK_DIV >= 2);
`endif

    assign o_caret_phase = caret_phase;
    assign caret_hit = caret_phase && !o_full && (i_rd_addr == o_cursor);

    // command FSM: edits cells and cursor, sweeps cells on CLEAR
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK_CHR;
            o_cursor   <= '0;
            o_full     <= 1'b0;
            state      <= ST_IDLE;
            o_wr_ready <= 1'b1;
            clr_idx    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_wr_valid) begin
                        unique case (cmd)
                            CMD_CHAR: begin
                                if (o_full) begin
                                    for (int i = 0; i < DEPTH - 1; i++)
                                        mem[i] <= mem[i+1];
                                    mem[DEPTH-1] <= i_wr_data;
                                end else if (o_cursor == LAST) begin
                                    mem[DEPTH-1] <= i_wr_data;
                                    o_full       <= 1'b1;
                                end else begin
                                    mem[o_cursor] <= i_wr_data;
                                    o_cursor      <= o_cursor + 1'b1;
                                end
                            end
                            CMD_BKSP: begin
                                if (o_full) begin
                                    mem[DEPTH-1] <= BLANK_CHR;
                                    o_full       <= 1'b0;
                                end else if (o_cursor != '0) begin
                                    mem[o_cursor - 1'b1] <= BLANK_CHR;
                                    o_cursor <= o_cursor - 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                state      <= ST_CLEAR;
                                o_wr_ready <= 1'b0;
                                clr_idx    <= '0;
                            end
                            CMD_HOME: begin
                                o_cursor <= '0;
                                o_full   <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    mem[clr_idx] <= BLANK_CHR;
                    if (clr_idx == LAST) begin
                        o_cursor   <= '0;
                        o_full     <= 1'b0;
                        state      <= ST_IDLE;
                        o_wr_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    // registered read port, caret glyph over the live cursor cell
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd_data <= BLANK_CHR;
        end else if (i_rd_en) begin
            o_rd_data <= caret_hit ? CARET_CHR : mem[i_rd_addr];
        end
    end

endmodule

// File: tb/tb_disp_scroll_buffer.sv
// Self-checking bench for disp_scroll_buffer against a line-editor model.
// Directed spec scenarios followed by randomized command/read traffic.
module tb_disp_scroll_buffer;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DIV   = 4;
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CARET = 8'h5F;
`ifdef DISP_CARET_EN
    localparam bit CARET_EN = 1'b1;
`else
    localparam bit CARET_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [1:0]    cmd;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] cursor;
    logic          full;
    logic          caret_phase;

    int checks = 0;
    int errors = 0;

    // reference model: text line plus edit position
    logic [7:0] m_mem [DEPTH];
    int         m_cur;
    bit         m_full;
    int         m_clr;
    logic [7:0] m_rd;
    int         m_n;

    always #5 clk = ~clk;

    disp_scroll_buffer #(
        .DEPTH    (DEPTH),
        .DATA_W   (DW),
        .CARET_CHR(CARET),
        .BLANK_CHR(BLANK),
        .BLINK_DIV(DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_cmd        (cmd),
        .i_wr_data    (wr_data),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_cursor     (cursor),
        .o_full       (full),
        .o_caret_phase(caret_phase)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_phase(input int n);
        return CARET_EN ? (((n / DIV) % 2) == 1) : 1'b0;
    endfunction

    task automatic model_step();
        bit ph;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = BLANK;
            m_cur  = 0;
            m_full = 0;
            m_clr  = 0;
            m_rd   = BLANK;
            m_n    = 0;
            return;
        end
        ph = m_phase(m_n);
        if (rd_en)
            m_rd = (ph && !m_full && int'(rd_addr) == m_cur) ? CARET
                                                             : m_mem[rd_addr];
        m_n++;
        if (m_clr > 0) begin
            m_mem[DEPTH - m_clr] = BLANK;
            m_clr--;
            if (m_clr == 0) begin
                m_cur  = 0;
                m_full = 0;
            end
        end else if (wr_valid) begin
            case (cmd)
                2'd0: begin
                    if (m_full) begin
                        for (int i = 0; i < DEPTH - 1; i++) m_mem[i] = m_mem[i+1];
                        m_mem[DEPTH-1] = wr_data;
                    end else if (m_cur == DEPTH - 1) begin
                        m_mem[DEPTH-1] = wr_data;
                        m_full = 1;
                    end else begin
                        m_mem[m_cur] = wr_data;
                        m_cur++;
                    end
                end
                2'd1: begin
                    if (m_full) begin
                        m_mem[DEPTH-1] = BLANK;
                        m_full = 0;
                    end else if (m_cur > 0) begin
                        m_cur--;
                        m_mem[m_cur] = BLANK;
                    end
                end
                2'd2: m_clr = DEPTH;
                default: begin
                    m_cur  = 0;
                    m_full = 0;
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ready", wr_ready, m_clr == 0);
        chk("cursor", cursor, m_cur);
        chk("full", full, m_full);
        chk("rd_data", rd_data, m_rd);
        chk("phase", caret_phase, m_phase(m_n));
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        bit acc;
        int n;
        wr_valid = 1'b1;
        cmd      = c;
        wr_data  = d;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 64) begin
            acc = wr_ready;
            cycle();
            n++;
        end
        wr_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic read_chk(input string tag, input int a,
                            input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        cycle();
        chk(tag, rd_data, exp);
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        cmd      = 2'd0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        cycle();
        cycle();
        chk("rst_ready", wr_ready, 1);
        chk("rst_rd", rd_data, 8'h20);
        rst_n = 1'b1;
        cycle();

        send(2'd1, 8'h00);
        chk("bksp0_cursor", cursor, 0);

        send(2'd0, 8'h41);
        send(2'd0, 8'h42);
        send(2'd0, 8'h43);
        chk("abc_cursor", cursor, 3);
        chk("abc_full", full, 0);
        read_chk("abc_c0", 0, 8'h41);
        read_chk("abc_c1", 1, 8'h42);
        read_chk("abc_c2", 2, 8'h43);

        send(2'd3, 8'h00);
        chk("home_cursor", cursor, 0);
        for (int i = 0; i < 17; i++) begin
            send(2'd0, 8'(8'h30 + i));
            if (i == 15) chk("full16", full, 1);
        end
        chk("scroll_cursor", cursor, 15);
        for (int i = 0; i < DEPTH; i++)
            read_chk("scroll_cell", i, 8'(8'h31 + i));

        send(2'd1, 8'h00);
        chk("bkspf_full", full, 0);
        chk("bkspf_cursor", cursor, 15);
        read_chk("bkspf_c15", 15, 8'h20);

        wr_valid = 1'b1;
        cmd      = 2'd2;
        cycle();
        n = 0;
        while (!wr_ready && n < 40) begin
            n++;
            cycle();
        end
        chk("clear_busy", n, 16);
        cmd     = 2'd0;
        wr_data = 8'h5A;
        cycle();
        wr_valid = 1'b0;
        read_chk("clr_c0", 0, 8'h5A);
        read_chk("clr_c15", 15, 8'h20);
        read_chk("clr_c7", 7, 8'h20);

        send(2'd0, 8'h61);
        send(2'd2, 8'h00);
        for (int i = 0; i < 4; i++) cycle();
        rst_n = 1'b0;
        cycle();
        chk("rstclr_ready", wr_ready, 1);
        chk("rstclr_cursor", cursor, 0);
        chk("rstclr_rd", rd_data, 8'h20);
        rst_n = 1'b1;
        read_chk("rstclr_c0", 0, 8'h20);

        for (int k = 0; k < 1200; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 39);
            cmd = (r < 26) ? 2'd0 : (r < 35) ? 2'd1 : (r < 38) ? 2'd3 : 2'd2;
            wr_data = 8'($urandom);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom);
            cycle();
        end
        wr_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scroll_buffer.md
DISP_SCROLL_BUFFER -- requirements
Module: disp_scroll_buffer

Interface
REQ-001 Parameter DEPTH, default 16: number of character cells; SHALL be at least 2.
REQ-002 Parameter DATA_W, default 8: character width in bits.
REQ-003 Parameter CARET_CHR, default 8'h5F: glyph substituted at the cursor cell during caret phase.
REQ-004 Parameter BLANK_CHR, default 8'h20: fill glyph for clear, backspace and reset.
REQ-005 Parameter BLINK_DIV, default 6000000: clock cycles per caret phase; SHALL be at least 2.
REQ-006 Ports SHALL be, in order:
- i_clk  in  1  sole clock; all logic on its rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_wr_valid  in  1  command valid.
- o_wr_ready  out  1  command accepted when i_wr_valid and o_wr_ready are both high.
- i_cmd  in  2  command: 0 = CHAR, 1 = BKSP, 2 = CLEAR, 3 = HOME.
- i_wr_data  in  DATA_W  character for CHAR.
- i_rd_en  in  1  read strobe.
- i_rd_addr  in  clog2(DEPTH)  read cell index.
- o_rd_data  out  DATA_W  registered read data.
- o_cursor  out  clog2(DEPTH)  current write position.
- o_full  out  1  last cell written with cursor pinned.
- o_caret_phase  out  1  high while the caret glyph is shown.

Function
REQ-007 FSM states SHALL be IDLE and CLEAR; o_wr_ready SHALL be high only in IDLE.
REQ-008 CHAR, cursor < DEPTH-1: mem[cursor] = data; cursor + 1.
REQ-009 CHAR, cursor = DEPTH-1, o_full = 0: mem[DEPTH-1] = data; o_full = 1; cursor unchanged.
REQ-010 CHAR, o_full = 1: single-cycle left shift, mem[i] = mem[i+1] for i < DEPTH-1, then mem[DEPTH-1] = data; cursor and o_full unchanged.
REQ-011 BKSP, o_full = 1: mem[DEPTH-1] = BLANK_CHR; o_full = 0; cursor unchanged.
REQ-012 BKSP, o_full = 0, cursor > 0: cursor - 1; mem[cursor-1] = BLANK_CHR.
REQ-013 BKSP, o_full = 0, cursor = 0: no change, but the command is still accepted.
REQ-014 HOME: cursor = 0; o_full = 0; cell contents unchanged.
REQ-015 CLEAR: enter CLEAR state and write BLANK_CHR to cell k on the k-th cycle, k = 0..DEPTH-1. On the last write: cursor = 0, o_full = 0, return to IDLE. o_wr_ready is low for exactly DEPTH cycles.
REQ-016 Read latency SHALL be one cycle. o_rd_data updates only on cycles with i_rd_en high and otherwise holds.
REQ-017 Read-during-write to the same cell SHALL return the pre-write content.
REQ-018 Read with i_rd_addr = cursor, o_full = 0 and o_caret_phase = 1 SHALL return CARET_CHR; all other reads return mem[i_rd_addr].
REQ-019 Reads SHALL be serviced in every state, including CLEAR.
REQ-020 The blink counter SHALL count 0..BLINK_DIV-1 and wrap. o_caret_phase toggles on each wrap. The counter is free-running and unaffected by commands.

Reset
REQ-021 With i_rst_n low at a clock edge, the following SHALL be set:
- all cells = BLANK_CHR;
- cursor = 0, o_full = 0;
- state = IDLE, o_wr_ready = 1;
- o_rd_data = BLANK_CHR;
- blink counter = 0, o_caret_phase = 0.
REQ-022 Reset asserted mid-CLEAR SHALL abort the sweep and yield the REQ-021 state on the next cycle.

Configuration
REQ-023 Macro DISP_CARET_EN defined: the blink counter and the caret substitution of REQ-018 and REQ-020 are present.
REQ-024 Macro DISP_CARET_EN undefined: no blink counter; o_caret_phase is tied to 0; reads always return mem[i_rd_addr].

Structure
REQ-025 Package disp_pkg SHALL hold the command enum (CHAR, BKSP, CLEAR, HOME), the FSM state enum, and the default BLANK_CHR and CARET_CHR constants.
REQ-026 Sub-module disp_caret_blink SHALL contain the blink counter and phase flop. It is instantiated only under DISP_CARET_EN.

Verification
REQ-027 Reset, then CHAR 'A','B','C' with DEPTH=16 -> cells 0..2 = 41,42,43; o_cursor = 3; o_full = 0.
REQ-028 17 CHARs 0x30..0x40 -> after the 16th o_full = 1; after the 17th cells 0..15 = 0x31..0x40, o_cursor = 15.
REQ-029 CLEAR with i_wr_valid held high -> o_wr_ready low for 16 cycles; all cells 0x20; o_cursor = 0; a following CHAR lands in cell 0.
REQ-030 BKSP at cursor 0, then BKSP when o_full = 1 -> first is a no-op; second blanks cell 15, clears o_full, o_cursor stays 15.
REQ-031 DISP_CARET_EN, BLINK_DIV=4, cursor = 2, continuous reads of addr 2 -> o_rd_data alternates cell content / 0x5F every 4 cycles, with one-cycle latency.
REQ-032 i_rst_n low at cycle 5 of a CLEAR -> next cycle shows the REQ-021 state, o_wr_ready = 1.
